// File: rtl/fetch_bus_arbiter.sv
// Two-requester TileLink-UH fetch arbiter with a single outstanding transaction and D-burst routing.
// Define FETCH_BUS_ARB_FIXED_PRIO_EN to give requester 0 fixed priority on ties (default: round-robin).
module fetch_bus_arbiter #(
    parameter int unsigned MAX_LGSIZE = 6
) (
    input  logic        core_clock_i,
    input  logic        core_reset_ni,
    input  logic [2:0]  r0_a_opcode,
    input  logic [2:0]  r0_a_param,
    input  logic [3:0]  r0_a_size,
    input  logic [31:0] r0_a_address,
    input  logic [3:0]  r0_a_mask,
    input  logic [31:0] r0_a_data,
    input  logic        r0_a_corrupt,
    input  logic        r0_a_valid,
    output logic        r0_a_ready,
    output logic [2:0]  r0_d_opcode,
    output logic [1:0]  r0_d_param,
    output logic [3:0]  r0_d_size,
    output logic        r0_d_denied,
    output logic [31:0] r0_d_data,
    output logic        r0_d_corrupt,
    output logic        r0_d_valid,
    input  logic        r0_d_ready,
    input  logic [2:0]  r1_a_opcode,
    input  logic [2:0]  r1_a_param,
    input  logic [3:0]  r1_a_size,
    input  logic [31:0] r1_a_address,
    input  logic [3:0]  r1_a_mask,
    input  logic [31:0] r1_a_data,
    input  logic        r1_a_corrupt,
    input  logic        r1_a_valid,
    output logic        r1_a_ready,
    output logic [2:0]  r1_d_opcode,
    output logic [1:0]  r1_d_param,
    output logic [3:0]  r1_d_size,
    output logic        r1_d_denied,
    output logic [31:0] r1_d_data,
    output logic        r1_d_corrupt,
    output logic        r1_d_valid,
    input  logic        r1_d_ready,
    output logic [2:0]  m_a_opcode,
    output logic [2:0]  m_a_param,
    output logic [3:0]  m_a_size,
    output logic [31:0] m_a_address,
    output logic [3:0]  m_a_mask,
    output logic [31:0] m_a_data,
    output logic        m_a_corrupt,
    output logic        m_a_valid,
    input  logic        m_a_ready,
    input  logic [2:0]  m_d_opcode,
    input  logic [1:0]  m_d_param,
    input  logic [3:0]  m_d_size,
    input  logic        m_d_denied,
    input  logic [31:0] m_d_data,
    input  logic        m_d_corrupt,
    input  logic        m_d_valid,
    output logic        m_d_ready,
    output logic        grant_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [3:0] MaxSize = 4'(MAX_LGSIZE);
    localparam logic [2:0] OpGet   = 3'd4;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pick;
    logic        sel_a_valid, sel_d_ready;
    logic        a_hs, d_hs, burst_done;
    logic [3:0]  eff_size, beats_m1;
    logic [15:0] beats_full, beats_m1_full;

    assign sel_a_valid = grant_q ? r1_a_valid : r0_a_valid;
    assign sel_d_ready = grant_q ? r1_d_ready : r0_d_ready;
    assign a_hs        = (state_q == StAddr) & sel_a_valid & m_a_ready;
    assign d_hs        = (state_q == StData) & m_d_valid & sel_d_ready;
    assign burst_done  = d_hs & (cnt_q == 4'd0);

`ifdef FETCH_BUS_ARB_FIXED_PRIO_EN
    assign pick = ~r0_a_valid;
`else
    logic last_q;

    // On a tie the requester that did not finish the previous burst wins.
    assign pick = (r0_a_valid & r1_a_valid) ? ~last_q : r1_a_valid;

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) last_q <= 1'b1;
        else if (burst_done) last_q <= grant_q;
    end
`endif

    // Get bursts move 2^(size-2) beats; everything else answers with a single beat.
    assign eff_size      = (m_a_size > MaxSize) ? MaxSize : m_a_size;
    assign beats_full    = 16'd1 << (eff_size - 4'd2);
    assign beats_m1_full = beats_full - 16'd1;
    assign beats_m1      = (m_a_opcode != OpGet || eff_size <= 4'd2) ? 4'd0 : beats_m1_full[3:0];

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) state_q <= StIdle;
        else state_q <= state_d;
    end

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            grant_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (r0_a_valid | r1_a_valid) begin
                    grant_d = pick;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (a_hs) begin
                    cnt_d   = beats_m1;
                    state_d = StData;
                end
            end
            StData: begin
                if (burst_done) state_d = StIdle;
                else if (d_hs) cnt_d = cnt_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_a_opcode  = grant_q ? r1_a_opcode  : r0_a_opcode;
        m_a_param   = grant_q ? r1_a_param   : r0_a_param;
        m_a_size    = grant_q ? r1_a_size    : r0_a_size;
        m_a_address = grant_q ? r1_a_address : r0_a_address;
        m_a_mask    = grant_q ? r1_a_mask    : r0_a_mask;
        m_a_data    = grant_q ? r1_a_data    : r0_a_data;
        m_a_corrupt = grant_q ? r1_a_corrupt : r0_a_corrupt;
        m_a_valid   = (state_q == StAddr) & sel_a_valid;
        r0_a_ready  = (state_q == StAddr) & ~grant_q & m_a_ready;
        r1_a_ready  = (state_q == StAddr) & grant_q & m_a_ready;
        m_d_ready   = (state_q == StData) & sel_d_ready;
        r0_d_valid  = (state_q == StData) & ~grant_q & m_d_valid;
        r1_d_valid  = (state_q == StData) & grant_q & m_d_valid;
        busy_o      = (state_q != StIdle);
        grant_o     = grant_q;
    end

    assign r0_d_opcode  = m_d_opcode;
    assign r0_d_param   = m_d_param;
    assign r0_d_size    = m_d_size;
    assign r0_d_denied  = m_d_denied;
    assign r0_d_data    = m_d_data;
    assign r0_d_corrupt = m_d_corrupt;
    assign r1_d_opcode  = m_d_opcode;
    assign r1_d_param   = m_d_param;
    assign r1_d_size    = m_d_size;
    assign r1_d_denied  = m_d_denied;
    assign r1_d_data    = m_d_data;
    assign r1_d_corrupt = m_d_corrupt;

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Self-checking bench for fetch_bus_arbiter: directed bursts/ties/reset plus random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_fetch_bus_arbiter;

    logic        core_clock_i = 1'b0;
    logic        core_reset_ni = 1'b0;
    logic [2:0]  r0_a_opcode, r0_a_param, r1_a_opcode, r1_a_param, m_a_opcode, m_a_param;
    logic [3:0]  r0_a_size, r0_a_mask, r1_a_size, r1_a_mask, m_a_size, m_a_mask;
    logic [31:0] r0_a_address, r0_a_data, r1_a_address, r1_a_data, m_a_address, m_a_data;
    logic        r0_a_corrupt, r0_a_valid, r0_a_ready, r1_a_corrupt, r1_a_valid, r1_a_ready;
    logic        m_a_corrupt, m_a_valid, m_a_ready;
    logic [2:0]  r0_d_opcode, r1_d_opcode, m_d_opcode;
    logic [1:0]  r0_d_param, r1_d_param, m_d_param;
    logic [3:0]  r0_d_size, r1_d_size, m_d_size;
    logic        r0_d_denied, r1_d_denied, m_d_denied;
    logic [31:0] r0_d_data, r1_d_data, m_d_data;
    logic        r0_d_corrupt, r1_d_corrupt, m_d_corrupt;
    logic        r0_d_valid, r1_d_valid, m_d_valid, r0_d_ready, r1_d_ready, m_d_ready;
    logic        grant_o, busy_o;

    always #5 core_clock_i = ~core_clock_i;

    fetch_bus_arbiter dut (
        .core_clock_i(core_clock_i), .core_reset_ni(core_reset_ni),
        .r0_a_opcode(r0_a_opcode), .r0_a_param(r0_a_param), .r0_a_size(r0_a_size),
        .r0_a_address(r0_a_address), .r0_a_mask(r0_a_mask), .r0_a_data(r0_a_data),
        .r0_a_corrupt(r0_a_corrupt), .r0_a_valid(r0_a_valid), .r0_a_ready(r0_a_ready),
        .r0_d_opcode(r0_d_opcode), .r0_d_param(r0_d_param), .r0_d_size(r0_d_size),
        .r0_d_denied(r0_d_denied), .r0_d_data(r0_d_data), .r0_d_corrupt(r0_d_corrupt),
        .r0_d_valid(r0_d_valid), .r0_d_ready(r0_d_ready),
        .r1_a_opcode(r1_a_opcode), .r1_a_param(r1_a_param), .r1_a_size(r1_a_size),
        .r1_a_address(r1_a_address), .r1_a_mask(r1_a_mask), .r1_a_data(r1_a_data),
        .r1_a_corrupt(r1_a_corrupt), .r1_a_valid(r1_a_valid), .r1_a_ready(r1_a_ready),
        .r1_d_opcode(r1_d_opcode), .r1_d_param(r1_d_param), .r1_d_size(r1_d_size),
        .r1_d_denied(r1_d_denied), .r1_d_data(r1_d_data), .r1_d_corrupt(r1_d_corrupt),
        .r1_d_valid(r1_d_valid), .r1_d_ready(r1_d_ready),
        .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
        .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
        .m_a_corrupt(m_a_corrupt), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
        .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
        .m_d_denied(m_d_denied), .m_d_data(m_d_data), .m_d_corrupt(m_d_corrupt),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
        .grant_o(grant_o), .busy_o(busy_o)
    );

`ifdef FETCH_BUS_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] a0_f, a1_f, ma_f, d_src, d0_f, d1_f;
    assign a0_f  = 128'({r0_a_opcode, r0_a_param, r0_a_size, r0_a_address, r0_a_mask,
                         r0_a_data, r0_a_corrupt});
    assign a1_f  = 128'({r1_a_opcode, r1_a_param, r1_a_size, r1_a_address, r1_a_mask,
                         r1_a_data, r1_a_corrupt});
    assign ma_f  = 128'({m_a_opcode, m_a_param, m_a_size, m_a_address, m_a_mask,
                         m_a_data, m_a_corrupt});
    assign d_src = 128'({m_d_opcode, m_d_param, m_d_size, m_d_denied, m_d_data, m_d_corrupt});
    assign d0_f  = 128'({r0_d_opcode, r0_d_param, r0_d_size, r0_d_denied, r0_d_data,
                         r0_d_corrupt});
    assign d1_f  = 128'({r1_d_opcode, r1_d_param, r1_d_size, r1_d_denied, r1_d_data,
                         r1_d_corrupt});

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner (-1 = nobody), address phase flag, beats still owed.
    int own = -1;
    bit adr = 1'b0;
    int left = 0;
    int prev = 1;
    int shown = 0;

    function automatic int beats_of(input logic [2:0] op, input logic [3:0] sz);
        int s;
        if (op != 3'd4 || sz <= 4'd2) return 1;
        s = (sz > 4'd6) ? 6 : int'(sz);
        return 1 << (s - 2);
    endfunction

    task automatic model_step();
        logic [1:0] av, dr;
        logic [7:0] exp_ctrl, act_ctrl;
        bit mav, ow;
        act_ctrl = {busy_o, grant_o, m_a_valid, r0_a_ready, r1_a_ready, m_d_ready,
                    r0_d_valid, r1_d_valid};
        if (!core_reset_ni) begin
            chk("reset_ctrl", 128'(act_ctrl), 128'(8'h00));
            own = -1; adr = 1'b0; left = 0; prev = 1; shown = 0;
            return;
        end
        av  = {r1_a_valid, r0_a_valid};
        dr  = {r1_d_ready, r0_d_ready};
        ow  = (own == 1);
        mav = (own >= 0) && adr && av[ow];
        exp_ctrl = {own >= 0, shown == 1, mav,
                    own == 0 && adr && m_a_ready, own == 1 && adr && m_a_ready,
                    own >= 0 && !adr && dr[ow],
                    own == 0 && !adr && m_d_valid, own == 1 && !adr && m_d_valid};
        chk("ctrl", 128'(act_ctrl), 128'(exp_ctrl));
        if (mav) chk("a_fields", ma_f, ow ? a1_f : a0_f);
        if (exp_ctrl[1]) chk("d0_fields", d0_f, d_src);
        if (exp_ctrl[0]) chk("d1_fields", d1_f, d_src);
        if (own < 0) begin
            if (av != 2'b00) begin
                if (av == 2'b11) own = FixedPrio ? 0 : 1 - prev;
                else own = av[1] ? 1 : 0;
                adr = 1'b1;
                shown = own;
            end
        end else if (adr) begin
            if (mav && m_a_ready) begin
                left = ow ? beats_of(r1_a_opcode, r1_a_size) : beats_of(r0_a_opcode, r0_a_size);
                adr = 1'b0;
            end
        end else if (m_d_valid && dr[ow]) begin
            left--;
            if (left == 0) begin
                prev = own;
                own = -1;
            end
        end
    endtask

    // Model compare on the falling edge; returns 1 time unit after the next rising edge.
    task automatic cycle();
        @(negedge core_clock_i);
        model_step();
        @(posedge core_clock_i);
        #1;
    endtask

    task automatic set_idle();
        r0_a_valid = 1'b0; r1_a_valid = 1'b0; m_a_ready = 1'b1; m_d_valid = 1'b0;
        m_d_denied = 1'b0; r0_d_ready = 1'b1; r1_d_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        core_reset_ni = 1'b0;
        cycle();
        core_reset_ni = 1'b1;
    endtask

    task automatic do_txn(input int who, input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] addr, input int deny_beat, input int rst_beat,
                          output int beats, output int stray, output int first_ma,
                          output int g_at_ma, output int addr_at_ma, output int deny_seen,
                          output int idle_gap);
        bit drop, started, stop;
        int last_beat;
        if (who == 0) begin
            r0_a_opcode = op; r0_a_param = 3'd0; r0_a_size = sz; r0_a_address = addr;
            r0_a_mask = 4'hf; r0_a_data = 32'd0; r0_a_corrupt = 1'b0; r0_a_valid = 1'b1;
        end else begin
            r1_a_opcode = op; r1_a_param = 3'd0; r1_a_size = sz; r1_a_address = addr;
            r1_a_mask = 4'hf; r1_a_data = 32'd0; r1_a_corrupt = 1'b0; r1_a_valid = 1'b1;
        end
        m_a_ready = 1'b1; m_d_valid = 1'b1; m_d_denied = (deny_beat == 1);
        r0_d_ready = 1'b1; r1_d_ready = 1'b1;
        beats = 0; stray = 0; first_ma = -1; g_at_ma = -1; addr_at_ma = 0; deny_seen = 0;
        idle_gap = -1; last_beat = -1; drop = 1'b0; started = 1'b0; stop = 1'b0;
        for (int i = 0; i < 80 && !stop; i++) begin
            cycle();
            m_d_data = $urandom;
            if (drop) begin r0_a_valid = 1'b0; r1_a_valid = 1'b0; end
            drop = (r0_a_valid && r0_a_ready) || (r1_a_valid && r1_a_ready);
            if (m_a_valid && first_ma < 0) begin
                first_ma = i; g_at_ma = int'(grant_o); addr_at_ma = int'(m_a_address);
            end
            if (busy_o) started = 1'b1;
            if (who == 0 ? r0_d_valid : r1_d_valid) begin
                beats++;
                last_beat = i;
                if (who == 0 ? r0_d_denied : r1_d_denied) deny_seen = beats;
                m_d_denied = (beats + 1 == deny_beat);
                if (beats == rst_beat) begin
                    core_reset_ni = 1'b0;
                    stop = 1'b1;
                end
            end
            if (who == 0 ? r1_d_valid : r0_d_valid) stray++;
            if (!stop && started && !busy_o) begin
                idle_gap = i - last_beat;
                stop = 1'b1;
            end
        end
        m_d_valid = 1'b0;
        m_d_denied = 1'b0;
    endtask

    task automatic wait_idle();
        bit drop, done;
        drop = 1'b0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle();
            if (drop) begin r0_a_valid = 1'b0; r1_a_valid = 1'b0; end
            drop = (r0_a_valid && r0_a_ready) || (r1_a_valid && r1_a_ready);
            done = !busy_o && !r0_a_valid && !r1_a_valid;
        end
        chk_i("wait_idle_done", int'(done), 1);
        set_idle();
    endtask

    task automatic do_ties(output int g0, output int g1, output int g2, output int gap1);
        int n, last_beat;
        bit prev_busy;
        r0_a_opcode = 3'd4; r0_a_param = 3'd0; r0_a_size = 4'd2; r0_a_address = 32'h2000;
        r0_a_mask = 4'hf; r0_a_data = 32'd0; r0_a_corrupt = 1'b0;
        r1_a_opcode = 3'd4; r1_a_param = 3'd0; r1_a_size = 4'd2; r1_a_address = 32'h3000;
        r1_a_mask = 4'hf; r1_a_data = 32'd0; r1_a_corrupt = 1'b0;
        r0_a_valid = 1'b1; r1_a_valid = 1'b1; m_a_ready = 1'b1; m_d_valid = 1'b1;
        m_d_denied = 1'b0; r0_d_ready = 1'b1; r1_d_ready = 1'b1;
        g0 = -1; g1 = -1; g2 = -1; gap1 = -1; n = 0; last_beat = -1; prev_busy = busy_o;
        for (int i = 0; i < 60 && n < 3; i++) begin
            cycle();
            if (r0_d_valid || r1_d_valid) last_beat = i;
            if (busy_o && !prev_busy) begin
                if (n == 0) g0 = int'(grant_o);
                if (n == 1) begin g1 = int'(grant_o); gap1 = i - last_beat; end
                if (n == 2) g2 = int'(grant_o);
                n++;
            end
            prev_busy = busy_o;
        end
        if (grant_o) r0_a_valid = 1'b0;
        else r1_a_valid = 1'b0;
        wait_idle();
    endtask

    function automatic logic [2:0] rand_op();
        case ($urandom_range(0, 3))
            0: return 3'd0;
            1: return 3'd1;
            default: return 3'd4;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, stray, first_ma, g_ma, a_ma, deny_seen, gap, g0, g1, g2, gap1;
        r0_a_opcode = 3'd0; r0_a_param = 3'd0; r0_a_size = 4'd0; r0_a_address = 32'd0;
        r0_a_mask = 4'd0; r0_a_data = 32'd0; r0_a_corrupt = 1'b0;
        r1_a_opcode = 3'd0; r1_a_param = 3'd0; r1_a_size = 4'd0; r1_a_address = 32'd0;
        r1_a_mask = 4'd0; r1_a_data = 32'd0; r1_a_corrupt = 1'b0;
        m_d_opcode = 3'd1; m_d_param = 2'd0; m_d_size = 4'd2; m_d_data = 32'd0;
        m_d_corrupt = 1'b0;
        set_idle();
        r0_a_valid = 1'b1; r1_a_valid = 1'b1; m_d_valid = 1'b1;
        #2;
        chk_i("reset_busy", int'(busy_o), 0);
        chk_i("reset_grant", int'(grant_o), 0);
        chk_i("reset_m_a_valid", int'(m_a_valid), 0);
        chk_i("reset_d_valids", int'({r0_d_valid, r1_d_valid, m_d_ready}), 0);
        repeat (2) cycle();
        set_idle();
        core_reset_ni = 1'b1;
        cycle();

        // Lone 16-beat Get from r0.
        do_txn(0, 3'd4, 4'd6, 32'h1000, 0, 0, beats, stray, first_ma, g_ma, a_ma, deny_seen, gap);
        chk_i("get16_first_ma", first_ma, 0);
        chk_i("get16_grant", g_ma, 0);
        chk_i("get16_addr", a_ma, 32'h1000);
        chk_i("get16_beats", beats, 16);
        chk_i("get16_stray", stray, 0);
        chk_i("get16_idle_gap", gap, 1);
        set_idle();

        // Ties after reset: r0, then r1 (or r0 with fixed priority), then r0.
        pulse_reset();
        do_ties(g0, g1, g2, gap1);
        chk_i("tie_first", g0, 0);
        chk_i("tie_second", g1, FixedPrio ? 0 : 1);
        chk_i("tie_third", g2, 0);
        chk_i("tie_regrant_gap", gap1, 2);

        // PutFull from r1 answers with one beat.
        do_txn(1, 3'd0, 4'd2, 32'h40, 0, 0, beats, stray, first_ma, g_ma, a_ma, deny_seen, gap);
        chk_i("put_grant", g_ma, 1);
        chk_i("put_beats", beats, 1);
        chk_i("put_r0_stray", stray, 0);
        chk_i("put_idle_gap", gap, 1);
        set_idle();

        // Denied beat 3 of an 8-beat Get does not shorten the burst.
        do_txn(0, 3'd4, 4'd5, 32'h80, 3, 0, beats, stray, first_ma, g_ma, a_ma, deny_seen, gap);
        chk_i("deny_beats", beats, 8);
        chk_i("deny_seen_beat", deny_seen, 3);
        chk_i("deny_idle_gap", gap, 1);
        set_idle();

        // Reset mid-burst at beat 5 of 16; last_grant was 0, so reset must restore r0 priority.
        do_txn(0, 3'd4, 4'd6, 32'h1000, 0, 5, beats, stray, first_ma, g_ma, a_ma, deny_seen, gap);
        #1;
        chk_i("midrst_beats", beats, 5);
        chk_i("midrst_busy", int'(busy_o), 0);
        chk_i("midrst_grant", int'(grant_o), 0);
        chk_i("midrst_valids", int'({m_d_ready, r0_d_valid, r1_d_valid, m_a_valid}), 0);
        set_idle();
        cycle();
        core_reset_ni = 1'b1;
        do_ties(g0, g1, g2, gap1);
        chk_i("post_rst_tie_first", g0, 0);
        chk_i("post_rst_tie_second", g1, FixedPrio ? 0 : 1);

        // Random traffic, including protocol-violating withdrawals and async reset pulses.
        for (int i = 0; i < 3000; i++) begin
            if (!core_reset_ni) core_reset_ni = 1'b1;
            else if ($urandom_range(0, 499) == 0) core_reset_ni = 1'b0;
            r0_a_valid = ($urandom_range(0, 3) != 0);
            r1_a_valid = ($urandom_range(0, 3) != 0);
            r0_a_opcode = rand_op(); r0_a_param = 3'($urandom); r0_a_size = 4'($urandom_range(0, 7));
            r0_a_address = $urandom; r0_a_mask = 4'($urandom); r0_a_data = $urandom;
            r0_a_corrupt = 1'($urandom);
            r1_a_opcode = rand_op(); r1_a_param = 3'($urandom); r1_a_size = 4'($urandom_range(0, 7));
            r1_a_address = $urandom; r1_a_mask = 4'($urandom); r1_a_data = $urandom;
            r1_a_corrupt = 1'($urandom);
            m_a_ready = 1'($urandom);
            m_d_valid = ($urandom_range(0, 3) != 0);
            m_d_opcode = 3'($urandom); m_d_param = 2'($urandom); m_d_size = 4'($urandom);
            m_d_denied = 1'($urandom); m_d_data = $urandom; m_d_corrupt = 1'($urandom);
            r0_d_ready = ($urandom_range(0, 3) != 0);
            r1_d_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_bus_arbiter.md
FETCH_BUS_ARBITER -- requirements
Module: fetch_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_LGSIZE, default 6: largest supported a_size (log2 bytes), giving 16 beats of 32 bits.
REQ-002 SHALL have port core_clock_i, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port core_reset_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports rN_a_opcode/param/size/address/mask/data/corrupt (N=0,1), inputs, 3/3/4/32/4/32/1: requester N TileLink-UH A fields.
REQ-005 SHALL have ports rN_a_valid input 1, rN_a_ready output 1: requester N A handshake.
REQ-006 SHALL have ports rN_d_opcode/param/size/denied/data/corrupt, outputs, 3/2/4/1/32/1: D fields forwarded to requester N.
REQ-007 SHALL have ports rN_d_valid output 1, rN_d_ready input 1: requester N D handshake.
REQ-008 SHALL have ports m_a_* outputs and m_a_ready input, matching REQ-004/005 widths: shared A channel to the bus.
REQ-009 SHALL have ports m_d_* inputs and m_d_ready output, matching REQ-006/007 widths: shared D channel from the bus.
REQ-010 SHALL have ports grant_o output 1 (requester owning the bus) and busy_o output 1 (state not IDLE).

Function
REQ-011 SHALL implement a state machine with states IDLE, ADDR and DATA, allowing one outstanding transaction.
REQ-012 SHALL, in IDLE, register a grant when any rN_a_valid=1, set grant_o, and move to ADDR on the next edge; this gives 1 cycle of arbitration bubble.
REQ-013 SHALL, when both requesters are valid in IDLE, grant the requester other than last_grant (round-robin).
REQ-014 SHALL, in ADDR, drive m_a_* and m_a_valid combinationally from the granted requester, and drive r{grant}_a_ready = m_a_ready.
REQ-015 SHALL hold the non-granted rN_a_ready at 0, and hold m_a_valid at 0 outside ADDR.
REQ-016 SHALL, on the A handshake (m_a_valid & m_a_ready), load a 4-bit beat counter with beats-1 and enter DATA.
REQ-017 SHALL compute beats as 1 if opcode is not Get(4) or size<=2, otherwise 2^(size-2); sizes above MAX_LGSIZE SHALL clamp to MAX_LGSIZE.
REQ-018 SHALL, in DATA, forward m_d_* and m_d_valid to the granted requester, drive m_d_ready = r{grant}_d_ready, and drive the other rN_d_valid at 0.
REQ-019 SHALL hold m_d_ready at 0 and all rN_d_valid at 0 in IDLE and ADDR; m_d_valid in those states is not forwarded.
REQ-020 SHALL decrement the counter on each D handshake; a handshake with counter=0 SHALL set last_grant=grant and return to IDLE.
REQ-021 SHALL forward denied and corrupt unchanged and still count every beat; a denied response does not end the burst early.
REQ-022 SHALL keep the grant held while a requester withdraws rN_a_valid in ADDR; that is a protocol violation and is not arbitrated away.
REQ-023 SHALL let a requester that is returning to IDLE in one cycle be arbitrated again on the following cycle, with no extra bubble.

Reset
REQ-024 SHALL, on assertion of core_reset_ni at any time including mid-burst, asynchronously force state=IDLE, counter=0, grant_o=0 and last_grant=1, so requester 0 wins the first tie.
REQ-025 SHALL drive all valid and ready outputs, and busy_o, at 0 while in reset.

Configuration
REQ-026 SHALL, with macro FETCH_BUS_ARB_FIXED_PRIO_EN defined, always grant requester 0 on a tie; last_grant is then unused.
REQ-027 SHALL, without that macro, use the round-robin behaviour of REQ-013.

Verification
REQ-028 SHALL cover: r0 Get size=6 addr 0x1000 alone -> grant_o=0; m_a_valid 1 cycle after r0_a_valid; 16 beats routed to r0; IDLE after beat 16.
REQ-029 SHALL cover: r0 and r1 both valid after reset -> r0 is served first; r1 is granted the cycle after r0's last beat; a third tie goes to r0.
REQ-030 SHALL cover: r1 PutFull size=2 -> 1 AccessAck beat routed to r1; r0_d_valid stays 0 throughout.
REQ-031 SHALL cover: a denied=1 response on beat 3 of a size=5 Get -> all 8 beats are forwarded and the FSM leaves DATA only after beat 8.
REQ-032 SHALL cover: core_reset_ni pulsed low at beat 5 of 16 -> immediate IDLE with busy_o=0; the next tie is granted to r0.
REQ-033 SHALL cover: with FETCH_BUS_ARB_FIXED_PRIO_EN defined, three back-to-back ties -> r0 is granted every time.
